branch_pc_unit: RTL

//  Branch resolution + program counter stage directly downstream of the branch operand mux.

---
 rtl/branch_pc_if.sv | 46 ++++
 rtl/branch_pc_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/branch_pc_if.sv
// Bundle between the branch operand mux / decoder and the branch + PC stage.
// With BRANCH_STATS_EN defined, the bundle also carries the taken-branch counter BrTakenCnt.
interface branch_pc_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
);
  logic              Start;
  logic              Halt;
  logic              Stall;
  logic              Branch;
  logic [1:0]        BrCond;
  logic [7:0]        OperandA;
  logic [7:0]        OperandB;
  logic [LUT_AW-1:0] TargetIdx;
  logic              LutWe;
  logic [LUT_AW-1:0] LutWrIdx;
  logic [PC_W-1:0]   LutWrData;
  logic [PC_W-1:0]   PC;
  logic              Taken;
  logic              Flush;
  logic              Done;
  logic [1:0]        state_dbg;
`ifdef BRANCH_STATS_EN
  logic [15:0]       BrTakenCnt;
`endif

  // No valid/ready handshake: every input is sampled on each rising CLK edge
  // and every output is a registered value that is stable for the whole cycle.
  modport master (
    output Start, Halt, Stall, Branch, BrCond, OperandA, OperandB, TargetIdx,
           LutWe, LutWrIdx, LutWrData,
`ifdef BRANCH_STATS_EN
    input  BrTakenCnt,
`endif
    input  PC, Taken, Flush, Done, state_dbg
  );

  modport slave (
    input  Start, Halt, Stall, Branch, BrCond, OperandA, OperandB, TargetIdx,
           LutWe, LutWrIdx, LutWrData,
`ifdef BRANCH_STATS_EN
    output BrTakenCnt,
`endif
    output PC, Taken, Flush, Done, state_dbg
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution, branch-target LUT, program counter and run/halt FSM.
// Optional BRANCH_STATS_EN adds a saturating 16-bit taken-branch counter (BrTakenCnt).
module branch_pc_unit #(
  parameter int              PC_W       = 10,
  parameter int              LUT_AW     = 5,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input logic       CLK,
  input logic       Reset,
  branch_pc_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BUBBLE = 2'd2, HALTED = 2'd3} state_t;

  localparam int LUT_N = 2 ** LUT_AW;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic            taken, taken_n;
  logic            flush, flush_n;
  logic            cond_true;
  logic            start_go;
  logic [PC_W-1:0] lut [LUT_N];

  always_comb begin
    cond_true = 1'b0;
    case (bus.BrCond)
      2'b00:   cond_true = (bus.OperandA == bus.OperandB);
      2'b01:   cond_true = (bus.OperandA != bus.OperandB);
      2'b10:   cond_true = (bus.OperandA <  bus.OperandB);
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    taken_n  = 1'b0;
    flush_n  = 1'b0;
    start_go = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (bus.Start) begin
          start_go = 1'b1;
          pc_n     = START_ADDR;
          state_n  = RUN;
        end
      end
      RUN: begin
        // Halt outranks Stall so a stalled pipe can still be stopped.
        if (bus.Halt) begin
          state_n = HALTED;
        end else if (bus.Stall) begin
          state_n = RUN;
        end else if (bus.Branch && cond_true) begin
          pc_n    = lut[bus.TargetIdx];
          taken_n = 1'b1;
          flush_n = 1'b1;
          state_n = BUBBLE;
        end else begin
          pc_n = pc + PC_W'(1);
        end
      end
      BUBBLE: state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= START_ADDR;
      taken <= 1'b0;
      flush <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      taken <= taken_n;
      flush <= flush_n;
    end
  end

  // Registered array read combinationally: a same-cycle write is seen next cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (bus.LutWe) begin
      lut[bus.LutWrIdx] <= bus.LutWrData;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] br_cnt;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      br_cnt <= '0;
    end else if (start_go) begin
      br_cnt <= '0;
    end else if (taken_n && (br_cnt != 16'hFFFF)) begin
      br_cnt <= br_cnt + 16'd1;
    end
  end
  assign bus.BrTakenCnt = br_cnt;
`endif

  assign bus.PC        = pc;
  assign bus.Taken     = taken;
  assign bus.Flush     = flush;
  assign bus.Done      = (state == HALTED);
  assign bus.state_dbg = state;
endmodule
